// File: rtl/prog_loader_arbiter.sv
// Program-loader bus arbiter: freezes the CPU at a microstep boundary, then
// writes loader words into RAM via MAR/RAM strobes. Optional readback: PROG_LOADER_VERIFY_EN.
module prog_loader_arbiter #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DRAIN_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    input  logic              ld_last,
    input  logic [2:0]        cpu_step,
    input  logic              cpu_mi,
    input  logic              cpu_ri,
    input  logic              cpu_ro,
    input  logic [7:0]        bus_in,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              mi,
    output logic              ri,
    output logic              ro,
    output logic              hold,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int unsigned DCNT_W = $clog2(DRAIN_MAX + 1);
    localparam logic [ADDR_W:0] CNT_SAT = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        StIdle, StDrain, StWait, StAddr, StData, StVerify, StRelease, StErr
    } state_e;

    state_e            state_q, state_d;
    logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [7:0]        data_q;
    logic              last_q;
    logic              mi_q, ri_q, ro_q;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ld_valid) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                if (cpu_step == 3'd0) begin
                    state_d = StWait;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCNT_W'(1);
                    if (drain_cnt_d == DCNT_W'(DRAIN_MAX)) state_d = StErr;
                end
            end
            StWait:    if (ld_valid) state_d = StAddr;
            StAddr:    state_d = StData;
`ifdef PROG_LOADER_VERIFY_EN
            StData:    state_d = StVerify;
            StVerify: begin
                if (bus_in != data_q) state_d = StErr;
                else                  state_d = last_q ? StRelease : StWait;
            end
`else
            StData:    state_d = last_q ? StRelease : StWait;
            StVerify:  state_d = StIdle;
`endif
            StRelease: state_d = StIdle;
            StErr:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

`ifndef PROG_LOADER_VERIFY_EN
    logic unused_bus_in;
    assign unused_bus_in = ^bus_in;
`endif

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            data_q      <= '0;
            last_q      <= 1'b0;
            ld_ready    <= 1'b0;
            bus_oe      <= 1'b0;
            bus_out     <= '0;
            mi_q        <= 1'b0;
            ri_q        <= 1'b0;
            ro_q        <= 1'b0;
            hold        <= 1'b0;
            cpu_clr     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            word_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            if (state_q == StWait && ld_valid) begin
                data_q <= ld_data;
                last_q <= ld_last;
            end
            if (state_q == StIdle && ld_valid) begin
                err      <= 1'b0;
                word_cnt <= '0;
            end else begin
                if (state_d == StErr) err <= 1'b1;
                if (state_q == StData && word_cnt != CNT_SAT) begin
                    word_cnt <= word_cnt + (ADDR_W + 1)'(1);
                end
            end
            ld_ready <= (state_d == StWait);
            hold     <= (state_d != StIdle) && (state_d != StErr);
            busy     <= (state_d != StIdle) && (state_d != StErr);
            bus_oe   <= (state_d == StAddr) || (state_d == StData);
            // The address byte is captured straight off the loader port at handshake.
            if (state_d == StAddr)      bus_out <= 8'(ld_addr);
            else if (state_d == StData) bus_out <= data_q;
            else                        bus_out <= '0;
            mi_q    <= (state_d == StAddr);
            ri_q    <= (state_d == StData);
            ro_q    <= (state_d == StVerify);
            cpu_clr <= (state_d == StRelease);
            done    <= (state_d == StRelease);
        end
    end

    assign mi = busy ? mi_q : cpu_mi;
    assign ri = busy ? ri_q : cpu_ri;
    assign ro = busy ? ro_q : cpu_ro;

endmodule

// File: tb/tb_prog_loader_arbiter.sv
// Bench for prog_loader_arbiter: directed steps plus randomized sessions checked
// against a RAM/latency model; a tiny RAM behind the bus answers readbacks.
module tb_prog_loader_arbiter;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned DRAIN_MAX = 15;
`ifdef PROG_LOADER_VERIFY_EN
    localparam int PER = 4;
`else
    localparam int PER = 3;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ld_valid = 1'b0;
    logic             ld_ready;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [7:0]       ld_data = '0;
    logic             ld_last = 1'b0;
    logic [2:0]       cpu_step = '0;
    logic             cpu_mi = 1'b0, cpu_ri = 1'b0, cpu_ro = 1'b0;
    logic [7:0]       bus_in;
    logic [7:0]       bus_out;
    logic             bus_oe, mi, ri, ro, hold, cpu_clr, busy, done, err;
    logic [ADDR_W:0]  word_cnt;

    prog_loader_arbiter #(.ADDR_W(ADDR_W), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
        .ld_data(ld_data), .ld_last(ld_last), .cpu_step(cpu_step), .cpu_mi(cpu_mi),
        .cpu_ri(cpu_ri), .cpu_ro(cpu_ro), .bus_in(bus_in), .bus_out(bus_out),
        .bus_oe(bus_oe), .mi(mi), .ri(ri), .ro(ro), .hold(hold), .cpu_clr(cpu_clr),
        .busy(busy), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Bus-side RAM and pulse counters, sampled mid-cycle.
    logic [7:0] tb_ram [16];
    logic [7:0] mar = 8'h00;
    int mi_cnt = 0, ri_cnt = 0, ro_cnt = 0, done_cnt = 0, busy_cyc = 0;
    logic force_bad = 1'b0;

    assign bus_in = force_bad ? 8'h00 : tb_ram[mar[3:0]];

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cyc <= busy_cyc + 1;
            if (mi === 1'b1) begin
                mar    <= bus_out;
                mi_cnt <= mi_cnt + 1;
            end
            if (ri === 1'b1) begin
                tb_ram[mar[3:0]] <= bus_out;
                ri_cnt <= ri_cnt + 1;
            end
            if (ro === 1'b1) ro_cnt <= ro_cnt + 1;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic rand_cpu = 1'b0;
    logic [7:0] mem_exp [16];
    logic [3:0] w_addr [32];
    logic [7:0] w_data [32];
    int         w_gap  [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_cpu) {cpu_mi, cpu_ri, cpu_ro} = 3'($urandom);
    endtask

    task automatic send_words(input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            if (w_gap[i] > 0) begin
                ld_valid = 1'b0;
                for (int g = 0; g < w_gap[i]; g++) tick();
            end
            ld_valid = 1'b1;
            ld_addr  = w_addr[i];
            ld_data  = w_data[i];
            ld_last  = (i == n - 1);
            w = 0;
            while (ld_ready !== 1'b1 && w < 60) begin
                tick();
                w++;
            end
            chk("ld_ready_wait", {31'b0, ld_ready}, 32'd1);
            tick();
            mem_exp[w_addr[i]] = w_data[i];
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic run_session(input int n);
        int mi0, ri0, ro0, dn0, bc0, extra, w;
        mi0 = mi_cnt; ri0 = ri_cnt; ro0 = ro_cnt; dn0 = done_cnt; bc0 = busy_cyc;
        extra = 0;
        for (int i = 1; i < n; i++) if (w_gap[i] > PER - 1) extra += w_gap[i] - (PER - 1);
        send_words(n);
        w = 0;
        while (done !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        chk("done_pulse", {31'b0, done}, 32'd1);
        tick();
        chk("sess_mi_pulses", mi_cnt - mi0, n);
        chk("sess_ri_pulses", ri_cnt - ri0, n);
        chk("sess_ro_pulses", ro_cnt - ro0, n * (PER - 3));
        chk("sess_done_cnt", done_cnt - dn0, 1);
        chk("sess_busy_cycles", busy_cyc - bc0, 2 + n * PER + extra);
        chk("sess_word_cnt", 32'(word_cnt), (n > 16) ? 16 : n);
        chk("sess_err", {31'b0, err}, 32'd0);
        chk("sess_busy_end", {31'b0, busy}, 32'd0);
        for (int a = 0; a < 16; a++) chk($sformatf("ram[%0d]", a), 32'(tb_ram[a]), 32'(mem_exp[a]));
    endtask

    initial begin
        int hcnt, d0, n;
        // Reset state
        repeat (3) tick();
        chk("rst_ld_ready", {31'b0, ld_ready}, 0);
        chk("rst_bus_oe", {31'b0, bus_oe}, 0);
        chk("rst_hold", {31'b0, hold}, 0);
        chk("rst_cpu_clr", {31'b0, cpu_clr}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_bus_out", 32'(bus_out), 0);
        chk("rst_word_cnt", 32'(word_cnt), 0);
        rst = 1'b0;
        tick();

        // Idle pass-through
        cpu_mi = 1'b1; cpu_ri = 1'b0; cpu_ro = 1'b1;
        #1;
        chk("pt_mi", {31'b0, mi}, 1);
        chk("pt_ri", {31'b0, ri}, 0);
        chk("pt_ro", {31'b0, ro}, 1);
        cpu_mi = 1'b0; cpu_ri = 1'b1; cpu_ro = 1'b0;
        #1;
        chk("pt2_mi", {31'b0, mi}, 0);
        chk("pt2_ri", {31'b0, ri}, 1);
        chk("pt2_ro", {31'b0, ro}, 0);
        cpu_ri = 1'b0;

        // Single word, cycle by cycle
        cpu_step = 3'd0;
        ld_valid = 1'b1; ld_addr = 4'hA; ld_data = 8'h5C; ld_last = 1'b1;
        tick();
        chk("sw_drain_hold", {31'b0, hold}, 1);
        chk("sw_drain_busy", {31'b0, busy}, 1);
        chk("sw_drain_ready", {31'b0, ld_ready}, 0);
        tick();
        chk("sw_wait_ready", {31'b0, ld_ready}, 1);
        chk("sw_wait_hold", {31'b0, hold}, 1);
        tick();
        ld_valid = 1'b0; cpu_mi = 1'b0; cpu_ri = 1'b1;
        #1;
        chk("sw_addr_oe", {31'b0, bus_oe}, 1);
        chk("sw_addr_bus", 32'(bus_out), 32'h0A);
        chk("sw_addr_mi", {31'b0, mi}, 1);
        chk("sw_addr_ri_owned", {31'b0, ri}, 0);
        chk("sw_addr_ready", {31'b0, ld_ready}, 0);
        tick();
        chk("sw_data_bus", 32'(bus_out), 32'h5C);
        chk("sw_data_ri", {31'b0, ri}, 1);
        chk("sw_data_mi", {31'b0, mi}, 0);
`ifdef PROG_LOADER_VERIFY_EN
        tick();
        chk("sw_verify_ro", {31'b0, ro}, 1);
        chk("sw_verify_oe", {31'b0, bus_oe}, 0);
`endif
        tick();
        chk("sw_rel_clr", {31'b0, cpu_clr}, 1);
        chk("sw_rel_done", {31'b0, done}, 1);
        chk("sw_rel_hold", {31'b0, hold}, 1);
        chk("sw_rel_word_cnt", 32'(word_cnt), 1);
        tick();
        chk("sw_idle_hold", {31'b0, hold}, 0);
        chk("sw_idle_busy", {31'b0, busy}, 0);
        chk("sw_idle_done", {31'b0, done}, 0);
        chk("sw_idle_ri_pt", {31'b0, ri}, 1);
        mem_exp[4'hA] = 8'h5C;
        chk("sw_ram", 32'(tb_ram[4'hA]), 32'h5C);
        cpu_ri = 1'b0;

        // Drain wait: step stuck at 3 for 5 cycles
        cpu_step = 3'd3;
        ld_valid = 1'b1; ld_addr = 4'h3; ld_data = 8'h77; ld_last = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("dw_hold", {31'b0, hold}, 1);
            chk("dw_ready", {31'b0, ld_ready}, 0);
            tick();
        end
        cpu_step = 3'd0;
        tick();
        chk("dw_ready_up", {31'b0, ld_ready}, 1);
        chk("dw_err", {31'b0, err}, 0);
        tick();
        ld_valid = 1'b0;
        mem_exp[4'h3] = 8'h77;
        hcnt = 0;
        while (done !== 1'b1 && hcnt < 40) begin
            tick();
            hcnt++;
        end
        chk("dw_done", {31'b0, done}, 1);
        tick();

        // Drain timeout
        cpu_step = 3'd2;
        ld_valid = 1'b1; ld_addr = 4'h1; ld_data = 8'h11; ld_last = 1'b1;
        tick();
        hcnt = 0;
        while (hold === 1'b1 && hcnt < 40) begin
            hcnt++;
            tick();
        end
        ld_valid = 1'b0;
        chk("to_hold_cycles", hcnt, DRAIN_MAX);
        chk("to_err", {31'b0, err}, 1);
        chk("to_hold", {31'b0, hold}, 0);
        chk("to_busy", {31'b0, busy}, 0);
        cpu_mi = 1'b1; cpu_ri = 1'b1;
        #1;
        chk("to_pt_mi", {31'b0, mi}, 1);
        chk("to_pt_ri", {31'b0, ri}, 1);
        tick();
        chk("to_err_sticky", {31'b0, err}, 1);
        cpu_mi = 1'b0; cpu_ri = 1'b0;
        cpu_step = 3'd0;
        tick();

        // Burst of 16, ld_valid held high
        for (int i = 0; i < 16; i++) begin
            w_addr[i] = 4'(i);
            w_data[i] = 8'($urandom);
            w_gap[i]  = 0;
        end
        run_session(16);

        // Randomized sessions with repeats, gaps and CPU strobe noise
        rand_cpu = 1'b1;
        for (int s = 0; s < 6; s++) begin
            n = (s == 0) ? 20 : int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) begin
                w_addr[i] = 4'($urandom);
                w_data[i] = 8'($urandom);
                w_gap[i]  = (i == 0) ? 0 : int'($urandom_range(0, 4));
            end
            run_session(n);
            repeat (int'($urandom_range(0, 3))) tick();
        end
        rand_cpu = 1'b0;
        cpu_mi = 1'b0; cpu_ri = 1'b1; cpu_ro = 1'b0;

        // Reset during DATA
        d0 = done_cnt;
        ld_valid = 1'b1; ld_addr = 4'h5; ld_data = 8'h3C; ld_last = 1'b1;
        tick();
        tick();
        tick();
        ld_valid = 1'b0;
        tick();
        chk("rm_data_ri", {31'b0, ri}, 1);
        chk("rm_data_bus", 32'(bus_out), 32'h3C);
        mem_exp[4'h5] = 8'h3C;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_bus_oe", {31'b0, bus_oe}, 0);
        chk("rm_hold", {31'b0, hold}, 0);
        chk("rm_busy", {31'b0, busy}, 0);
        chk("rm_ri_pt", {31'b0, ri}, 1);
        chk("rm_word_cnt", 32'(word_cnt), 0);
        repeat (3) tick();
        chk("rm_no_done", done_cnt - d0, 0);
        cpu_ri = 1'b0;

`ifdef PROG_LOADER_VERIFY_EN
        // Readback mismatch aborts without RELEASE
        d0 = done_cnt;
        force_bad = 1'b1;
        ld_valid = 1'b1; ld_addr = 4'h2; ld_data = 8'h5C; ld_last = 1'b1;
        tick();
        tick();
        tick();
        ld_valid = 1'b0;
        tick();
        tick();
        chk("vf_ro", {31'b0, ro}, 1);
        chk("vf_oe", {31'b0, bus_oe}, 0);
        tick();
        chk("vf_err", {31'b0, err}, 1);
        chk("vf_hold", {31'b0, hold}, 0);
        tick();
        tick();
        chk("vf_err_sticky", {31'b0, err}, 1);
        chk("vf_no_done", done_cnt - d0, 0);
        force_bad = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
